// File: rtl/gmii_rx_latency_extract_if.sv
// rtl/gmii_rx_latency_extract_if.sv - GMII receive, rtclock and result bundle (optional min/max: GMII_RX_LATENCY_MINMAX_EN)
interface gmii_rx_latency_extract_if;
    logic [7:0]  gmii_d;
    logic        gmii_en;
    logic        gmii_er;
    logic [47:0] sec;
    logic [29:0] nsec;
    logic        res_valid;
    logic [63:0] res_seq;
    logic [47:0] res_tx_sec;
    logic [29:0] res_tx_nsec;
    logic [47:0] res_rx_sec;
    logic [29:0] res_rx_nsec;
    logic [31:0] res_latency_nsec;
    logic [15:0] res_frame_size;
    logic [3:0]  res_err;
`ifdef GMII_RX_LATENCY_MINMAX_EN
    logic        stats_clr;
    logic [31:0] lat_min_nsec;
    logic [31:0] lat_max_nsec;

    modport master (
        output gmii_d, gmii_en, gmii_er, sec, nsec, stats_clr,
        input  res_valid, res_seq, res_tx_sec, res_tx_nsec, res_rx_sec, res_rx_nsec,
               res_latency_nsec, res_frame_size, res_err, lat_min_nsec, lat_max_nsec
    );
    modport slave (
        input  gmii_d, gmii_en, gmii_er, sec, nsec, stats_clr,
        output res_valid, res_seq, res_tx_sec, res_tx_nsec, res_rx_sec, res_rx_nsec,
               res_latency_nsec, res_frame_size, res_err, lat_min_nsec, lat_max_nsec
    );
`else
    modport master (
        output gmii_d, gmii_en, gmii_er, sec, nsec,
        input  res_valid, res_seq, res_tx_sec, res_tx_nsec, res_rx_sec, res_rx_nsec,
               res_latency_nsec, res_frame_size, res_err
    );
    modport slave (
        input  gmii_d, gmii_en, gmii_er, sec, nsec,
        output res_valid, res_seq, res_tx_sec, res_tx_nsec, res_rx_sec, res_rx_nsec,
               res_latency_nsec, res_frame_size, res_err
    );
`endif
endinterface

// File: rtl/gmii_rx_latency_extract.sv
// rtl/gmii_rx_latency_extract.sv - GMII rx frame parser with tail seq/timestamp recovery and latency result (optional min/max: GMII_RX_LATENCY_MINMAX_EN)
module gmii_rx_latency_extract #(
    parameter int unsigned C_NSEC_PER_SEC = 1000000000,
    parameter logic [15:0] C_MAX_FRAME    = 16'hFFFF,
    parameter int unsigned C_TAIL_OCTETS  = 22
) (
    input  logic clk,
    input  logic rst,
    gmii_rx_latency_extract_if.slave bus
);
    localparam int unsigned C_TAIL_W = C_TAIL_OCTETS * 8;
    localparam logic [31:0] C_NS     = C_NSEC_PER_SEC[31:0];

    typedef enum logic [2:0] {
        S_WAIT_IDLE, S_IDLE, S_PREAMBLE, S_DATA, S_EXTRACT, S_CALC
    } state_t;

    state_t r_state, w_next;

    logic [C_TAIL_W-1:0] r_tail;
    logic [15:0] r_size;
    logic        r_er;
    logic [47:0] r_rx_sec;
    logic [29:0] r_rx_nsec;
    logic [63:0] r_seq;
    logic [47:0] r_tx_sec;
    logic [31:0] r_tx_nsec32;
    logic        r_short, r_ts_inv;

    logic        r_res_valid;
    logic [63:0] r_res_seq;
    logic [47:0] r_res_tx_sec, r_res_rx_sec;
    logic [29:0] r_res_tx_nsec, r_res_rx_nsec;
    logic [31:0] r_res_lat;
    logic [15:0] r_res_size;
    logic [3:0]  r_res_err;

    logic        w_sfd, w_shift, w_extract, w_calc, w_short_now;
    logic [47:0] w_d;
    logic [31:0] w_lat;
    logic        w_ovf;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_WAIT_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode of the GMII framing
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT_IDLE: if (!bus.gmii_en) w_next = S_IDLE;
            S_IDLE:      if (bus.gmii_en) w_next = (bus.gmii_d == 8'h55) ? S_PREAMBLE : S_WAIT_IDLE;
            S_PREAMBLE: begin
                if (!bus.gmii_en)              w_next = S_WAIT_IDLE;
                else if (bus.gmii_d == 8'hD5)  w_next = S_DATA;
                else if (bus.gmii_d != 8'h55)  w_next = S_WAIT_IDLE;
            end
            S_DATA:      if (!bus.gmii_en) w_next = S_EXTRACT;
            S_EXTRACT:   w_next = S_CALC;
            S_CALC:      w_next = bus.gmii_en ? S_WAIT_IDLE : S_IDLE;
            default:     w_next = S_WAIT_IDLE;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        w_sfd     = (r_state == S_PREAMBLE) && bus.gmii_en && (bus.gmii_d == 8'hD5);
        w_shift   = (r_state == S_DATA) && bus.gmii_en;
        w_extract = (r_state == S_EXTRACT);
        w_calc    = (r_state == S_CALC);
    end

    assign w_short_now = (r_size < 16'(C_TAIL_OCTETS));

    // Frame accumulation: size, sticky error, rx timestamp, tail shift, field extraction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tail      <= '0;
            r_size      <= '0;
            r_er        <= 1'b0;
            r_rx_sec    <= '0;
            r_rx_nsec   <= '0;
            r_seq       <= '0;
            r_tx_sec    <= '0;
            r_tx_nsec32 <= '0;
            r_short     <= 1'b0;
            r_ts_inv    <= 1'b0;
        end else begin
            if (w_sfd) begin
                r_size <= '0;
                r_er   <= 1'b0;
            end
            if (w_shift) begin
                r_tail <= {r_tail[C_TAIL_W-9:0], bus.gmii_d};
                if (r_size != C_MAX_FRAME) r_size <= r_size + 16'd1;
                if (bus.gmii_er)           r_er   <= 1'b1;
                if (r_size == 16'd0) begin
                    r_rx_sec  <= bus.sec;
                    r_rx_nsec <= bus.nsec;
                end
            end
            if (w_extract) begin
                r_short <= w_short_now;
                if (w_short_now) begin
                    r_seq       <= '0;
                    r_tx_sec    <= '0;
                    r_tx_nsec32 <= '0;
                    r_ts_inv    <= 1'b0;
                end else begin
                    r_seq       <= r_tail[C_TAIL_W-1   -: 64];
                    r_tx_sec    <= r_tail[C_TAIL_W-65  -: 48];
                    r_tx_nsec32 <= r_tail[C_TAIL_W-113 -: 32];
                    r_ts_inv    <= (r_tail[C_TAIL_W-113 -: 32] >= C_NS);
                end
            end
        end
    end

    // Latency: same-second difference, one-second borrow, otherwise saturate
    always_comb begin
        w_d   = r_rx_sec - r_tx_sec;
        w_lat = '0;
        w_ovf = 1'b0;
        if (r_short || r_ts_inv) begin
            w_lat = '0;
        end else if ((w_d == 48'd0) && ({2'b00, r_rx_nsec} >= r_tx_nsec32)) begin
            w_lat = {2'b00, r_rx_nsec} - r_tx_nsec32;
        end else if (w_d == 48'd1) begin
            w_lat = {2'b00, r_rx_nsec} + C_NS - r_tx_nsec32;
        end else begin
            w_lat = 32'hFFFF_FFFF;
            w_ovf = 1'b1;
        end
    end

    // Result record registered in CALC, strobe valid for the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid   <= 1'b0;
            r_res_seq     <= '0;
            r_res_tx_sec  <= '0;
            r_res_tx_nsec <= '0;
            r_res_rx_sec  <= '0;
            r_res_rx_nsec <= '0;
            r_res_lat     <= '0;
            r_res_size    <= '0;
            r_res_err     <= '0;
        end else begin
            r_res_valid <= w_calc;
            if (w_calc) begin
                r_res_seq     <= r_seq;
                r_res_tx_sec  <= r_tx_sec;
                r_res_tx_nsec <= r_tx_nsec32[29:0];
                r_res_rx_sec  <= r_rx_sec;
                r_res_rx_nsec <= r_rx_nsec;
                r_res_lat     <= w_lat;
                r_res_size    <= r_size;
                r_res_err     <= {r_ts_inv, w_ovf, r_short, r_er};
            end
        end
    end

    assign bus.res_valid        = r_res_valid;
    assign bus.res_seq          = r_res_seq;
    assign bus.res_tx_sec       = r_res_tx_sec;
    assign bus.res_tx_nsec      = r_res_tx_nsec;
    assign bus.res_rx_sec       = r_res_rx_sec;
    assign bus.res_rx_nsec      = r_res_rx_nsec;
    assign bus.res_latency_nsec = r_res_lat;
    assign bus.res_frame_size   = r_res_size;
    assign bus.res_err          = r_res_err;

`ifdef GMII_RX_LATENCY_MINMAX_EN
    logic [31:0] r_lat_min, r_lat_max;

    // Running min/max over error-free results; clear has priority over update
    always_ff @(posedge clk) begin
        if (rst || bus.stats_clr) begin
            r_lat_min <= 32'hFFFF_FFFF;
            r_lat_max <= 32'h0;
        end else if (r_res_valid && (r_res_err == 4'h0)) begin
            if (r_res_lat < r_lat_min) r_lat_min <= r_res_lat;
            if (r_res_lat > r_lat_max) r_lat_max <= r_res_lat;
        end
    end

    assign bus.lat_min_nsec = r_lat_min;
    assign bus.lat_max_nsec = r_lat_max;
`endif
endmodule

// File: tb/tb_gmii_rx_latency_extract.sv
// tb/tb_gmii_rx_latency_extract.sv - scoreboard bench for gmii_rx_latency_extract (covers GMII_RX_LATENCY_MINMAX_EN when defined)
module tb_gmii_rx_latency_extract;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gmii_rx_latency_extract_if ifc ();

    gmii_rx_latency_extract dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    typedef struct {
        logic [63:0] seq;
        logic [47:0] tx_sec;
        logic [29:0] tx_nsec;
        logic [47:0] rx_sec;
        logic [29:0] rx_nsec;
        logic [31:0] lat;
        logic [15:0] size;
        logic [3:0]  err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   n_valid = 0;
    int   v_before;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int n, input logic [63:0] seq, input logic [47:0] txs,
                                   input logic [31:0] txn, input logic [47:0] rxs,
                                   input logic [29:0] rxn, input bit er);
        exp_t   e;
        longint sd, diff;
        e.size    = 16'(n);
        e.rx_sec  = rxs;
        e.rx_nsec = rxn;
        e.err     = {3'b000, er};
        e.lat     = 32'h0;
        if (n < 22) begin
            e.seq = 64'h0; e.tx_sec = 48'h0; e.tx_nsec = 30'h0;
            e.err[1] = 1'b1;
        end else begin
            e.seq = seq; e.tx_sec = txs; e.tx_nsec = txn[29:0];
            if (txn >= 32'd1000000000) begin
                e.err[3] = 1'b1;
            end else begin
                sd   = longint'(rxs) - longint'(txs);
                diff = sd * 64'sd1000000000 + longint'(rxn) - longint'(txn);
                if ((sd == 0 && diff >= 0) || sd == 1) e.lat = diff[31:0];
                else begin e.lat = 32'hFFFF_FFFF; e.err[2] = 1'b1; end
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic octet(input logic [7:0] d, input bit er);
        ifc.gmii_d  = d;
        ifc.gmii_en = 1'b1;
        ifc.gmii_er = er;
        tick();
    endtask

    task automatic idle(input int n);
        ifc.gmii_en = 1'b0;
        ifc.gmii_er = 1'b0;
        ifc.gmii_d  = 8'h00;
        repeat (n) tick();
    endtask

    task automatic send_frame(input int n, input logic [63:0] seq, input logic [47:0] txs,
                              input logic [31:0] txn, input logic [47:0] rxs,
                              input logic [29:0] rxn, input int er_idx);
        logic [175:0] t;
        logic [7:0]   b;
        t = {seq, txs, txn, 32'hC0FF_EE11};
        sb.push_back(model(n, seq, txs, txn, rxs, rxn, er_idx >= 0 && er_idx < n));
        ifc.sec  = rxs + 48'd3;
        ifc.nsec = rxn + 30'd11;
        repeat (7) octet(8'h55, 1'b0);
        octet(8'hD5, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin ifc.sec = rxs; ifc.nsec = rxn; end
            else begin ifc.sec = rxs + 48'd3; ifc.nsec = rxn + 30'd11; end
            if (n >= 22 && i >= n - 22) b = t[175 - 8*(i - (n - 22)) -: 8];
            else b = 8'(i * 7 + 3);
            octet(b, i == er_idx);
        end
        ifc.gmii_en = 1'b0;
        ifc.gmii_er = 1'b0;
        ifc.gmii_d  = 8'h00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("valid_timing", 64'(ifc.res_valid), 64'(k == 3));
        end
        tick();
        idle(8);
    endtask

    // Scoreboard monitor: every result strobe must match the oldest pending expectation
    always @(negedge clk) begin
        if (ifc.res_valid === 1'b1) begin
            n_valid++;
            check("sb_nonempty_on_valid", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("res_seq",     ifc.res_seq,              mon_e.seq);
                check("res_tx_sec",  64'(ifc.res_tx_sec),      64'(mon_e.tx_sec));
                check("res_tx_nsec", 64'(ifc.res_tx_nsec),     64'(mon_e.tx_nsec));
                check("res_rx_sec",  64'(ifc.res_rx_sec),      64'(mon_e.rx_sec));
                check("res_rx_nsec", 64'(ifc.res_rx_nsec),     64'(mon_e.rx_nsec));
                check("res_latency", 64'(ifc.res_latency_nsec), 64'(mon_e.lat));
                check("res_size",    64'(ifc.res_frame_size),  64'(mon_e.size));
                check("res_err",     64'(ifc.res_err),         64'(mon_e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.gmii_d = 8'h00; ifc.gmii_en = 1'b0; ifc.gmii_er = 1'b0;
        ifc.sec = 48'd0; ifc.nsec = 30'd0;
`ifdef GMII_RX_LATENCY_MINMAX_EN
        ifc.stats_clr = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_valid",   64'(ifc.res_valid), 64'd0);
        check("rst_seq",     ifc.res_seq, 64'd0);
        check("rst_latency", 64'(ifc.res_latency_nsec), 64'd0);
        check("rst_size",    64'(ifc.res_frame_size), 64'd0);
        check("rst_err",     64'(ifc.res_err), 64'd0);
`ifdef GMII_RX_LATENCY_MINMAX_EN
        check("rst_min", 64'(ifc.lat_min_nsec), 64'hFFFF_FFFF);
        check("rst_max", 64'(ifc.lat_max_nsec), 64'd0);
`endif
        tick();
        rst = 1'b0;
        idle(4);

        // Normal, rollover, invalid ts, negative/large diffs, exact-22 boundary
        send_frame(64, 64'd5,  48'd123, 32'd1000,      48'd123, 30'd1680, -1);
        send_frame(64, 64'h0102_0304_0506_0708, 48'd123, 32'd999999900, 48'd124, 30'd40, -1);
        send_frame(64, 64'd9,  48'd123, 32'h3B9A_CA00, 48'd123, 30'd5000, -1);
        send_frame(64, 64'd10, 48'd125, 32'd100,       48'd123, 30'd100,  -1);
        send_frame(64, 64'd11, 48'd50,  32'd500,       48'd50,  30'd100,  -1);
        send_frame(30, 64'd12, 48'd7,   32'd100,       48'd8,   30'd50,   -1);
        send_frame(22, 64'hFEED_BEEF_0000_0001, 48'h0000_1234_5678, 32'd100, 48'h0000_1234_5679, 30'd50, -1);

        // Bad preamble followed by a frame-like burst in the same carrier: no result
        v_before = n_valid;
        octet(8'h55, 1'b0); octet(8'h55, 1'b0); octet(8'hAA, 1'b0);
        octet(8'h55, 1'b0); octet(8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) octet(8'(i), 1'b0);
        idle(12);
        check("bad_preamble_no_result", 64'(n_valid - v_before), 64'd0);

        // Short frame and gmii_er on octet 30
        send_frame(20, 64'd77, 48'd1, 32'd1, 48'd1, 30'd9, -1);
        send_frame(64, 64'd13, 48'd200, 32'd100, 48'd200, 30'd400, 30);

        // Reset mid-frame, released with carrier still up
        v_before = n_valid;
        repeat (7) octet(8'h55, 1'b0);
        octet(8'hD5, 1'b0);
        for (int i = 0; i < 10; i++) octet(8'(i + 1), 1'b0);
        rst = 1'b1;
        octet(8'h11, 1'b0);
        @(negedge clk);
        check("midrst_latency", 64'(ifc.res_latency_nsec), 64'd0);
        check("midrst_seq",     ifc.res_seq, 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) octet(8'(i + 40), 1'b0);
        idle(12);
        check("reset_frame_no_result", 64'(n_valid - v_before), 64'd0);
        send_frame(64, 64'd14, 48'd10, 32'd0, 48'd10, 30'd900, -1);

`ifdef GMII_RX_LATENCY_MINMAX_EN
        ifc.stats_clr = 1'b1; tick(); ifc.stats_clr = 1'b0;
        send_frame(64, 64'd20, 48'd123, 32'd1000, 48'd123, 30'd1680, -1);
        send_frame(64, 64'd21, 48'd123, 32'd1000, 48'd123, 30'd1300, -1);
        send_frame(64, 64'd22, 48'd123, 32'd1000, 48'd123, 30'd1900, -1);
        @(negedge clk);
        check("min_after_three", 64'(ifc.lat_min_nsec), 64'd300);
        check("max_after_three", 64'(ifc.lat_max_nsec), 64'd900);
        tick();
        ifc.stats_clr = 1'b1; tick(); ifc.stats_clr = 1'b0;
        @(negedge clk);
        check("min_after_clr", 64'(ifc.lat_min_nsec), 64'hFFFF_FFFF);
        check("max_after_clr", 64'(ifc.lat_max_nsec), 64'd0);
        tick();
`endif

        idle(4);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gmii_rx_latency_extract.md
Name: gmii_rx_latency_extract

Overview:
- Receive-side GMII stage between the GMII link and the traffic analyzer statistics.
- Parses each received frame and timestamps its first post-SFD octet with the local rtclock (sec/nsec).
- Recovers the 8-octet sequence number and 10-octet 1588 timestamp that the generator's dynamic mode appends before the 4-octet CRC.
- Emits one result record per frame (seq, tx/rx time, latency, size, error flags) for the analyzer counters and min/max logic.

Parameters:
- C_NSEC_PER_SEC, 1000000000: nanosecond rollover constant used in latency arithmetic.
- C_MAX_FRAME, 16'hFFFF: saturation value of the frame octet counter.
- C_TAIL_OCTETS, 22: tail length: 8 seq + 10 timestamp + 4 CRC. Fixed; other values unsupported.

Ports:
- clk  in  1  system clock; one GMII octet per cycle.
- rst  in  1  synchronous active-high reset.
- gmii_d  in  8  receive data.
- gmii_en  in  1  receive data valid.
- gmii_er  in  1  receive error.
- sec  in  48  rtclock seconds.
- nsec  in  30  rtclock nanoseconds.
- res_valid  out  1  one-cycle result strobe.
- res_seq  out  64  sequence number, big-endian from frame.
- res_tx_sec  out  48  frame timestamp seconds.
- res_tx_nsec  out  30  frame timestamp nanoseconds, low 30 bits of field.
- res_rx_sec  out  48  local arrival seconds.
- res_rx_nsec  out  30  local arrival nanoseconds.
- res_latency_nsec  out  32  rx minus tx in ns.
- res_frame_size  out  16  octets after SFD, including CRC.
- res_err  out  4  error flags: [0] gmii_er seen, [1] short, [2] latency overflow, [3] ts_invalid.

Behaviour:
- Reset:
  - All outputs are 0.
  - Tail shift register is cleared.
  - State goes to WAIT_IDLE; any partial frame is discarded with no result.
- States and transitions:
  - WAIT_IDLE -> IDLE when gmii_en=0.
  - IDLE -> PREAMBLE when gmii_en=1 and gmii_d=0x55.
  - IDLE -> WAIT_IDLE when gmii_en=1 and gmii_d is any other value; no result.
  - PREAMBLE holds while gmii_d=0x55.
  - PREAMBLE -> DATA on 0xD5.
  - PREAMBLE -> WAIT_IDLE on any other octet, or if gmii_en drops; no result.
  - DATA accumulates while gmii_en=1.
  - DATA -> EXTRACT on the first edge sampling gmii_en=0.
  - EXTRACT -> CALC unconditionally.
  - CALC -> IDLE if gmii_en=0; CALC -> WAIT_IDLE if gmii_en=1. That frame is lost (IFG violation).
- Rx timestamp: sec/nsec are latched on the edge that samples the first DATA octet.
- Frame size: counts DATA octets and saturates at C_MAX_FRAME.
- Tail buffer: 22-octet shift register updated every DATA cycle; the newest octet is the last CRC octet.
- Field extraction (EXTRACT), oldest tail octet first, big-endian:
  - octets 0-7 = seq.
  - octets 8-13 = tx_sec.
  - octets 14-17 = tx_nsec32.
- ts_invalid is set when tx_nsec32 >= C_NSEC_PER_SEC.
- Short frame: res_err[1] is set when size < 22. seq, tx fields and latency are then 0.
- gmii_er: res_err[0] is sticky for any DATA cycle with gmii_er=1. The frame is still processed.
- Latency (CALC), with d = rx_sec - tx_sec computed in 48 bits:
  - d=0 and rx_nsec >= tx_nsec: latency = rx_nsec - tx_nsec.
  - d=1: latency = rx_nsec + C_NSEC_PER_SEC - tx_nsec.
  - Any other case (negative, or d>=2): latency = 32'hFFFFFFFF and res_err[2]=1.
  - short or ts_invalid: latency = 0 and res_err[2]=0.
- Output timing:
  - res_* are registered in CALC and res_valid=1 for exactly the cycle after CALC. Latency is 2 cycles from the edge sampling gmii_en=0 to res_valid high.
  - res_* fields hold their values until the next result.
- sec/nsec wrap: rx latch takes both fields on the same edge. nsec rollover is handled by the d=1 case.

Optional Feature:
- Macro GMII_RX_LATENCY_MINMAX_EN.
- When defined, adds:
  - input stats_clr (1 bit).
  - outputs lat_min_nsec[31:0] (reset 32'hFFFFFFFF) and lat_max_nsec[31:0] (reset 0).
- Min/max update on res_valid, only when res_err=0. stats_clr restores the reset values.
- stats_clr coincident with an update: clear wins.
- When undefined, these ports and their logic are absent.

Test Plan:
- Normal frame: 7x55,D5 + 64 octets, tail seq=5, tx=(123 s, 1000 ns); rx latch (123, 1680) -> res_valid 1 cycle, latency=680, size=64, seq=5, err=0.
- Second rollover: tx=(123, 999999900), rx=(124, 40) -> latency=140, err=0.
- Bad timestamp and bad preamble:
  - tx_nsec32=0x3B9ACA00 -> err[3]=1, latency=0.
  - tx_sec=125 with rx_sec=123 -> latency=FFFFFFFF, err[2]=1.
  - preamble 55,55,AA -> no res_valid.
- Short frame and gmii_er:
  - 20-octet frame -> size=20, err[1]=1, seq=0.
  - 64-octet frame with gmii_er high on octet 30 -> err[0]=1, latency still correct.
- Reset handling: rst asserted during DATA octet 10, released while gmii_en=1 -> no result for that frame; next clean frame produces a correct result.
- MINMAX_EN: latencies 680, 300, 900 -> min=300, max=900; stats_clr -> FFFFFFFF/0.
